// File: rtl/fa_bist_controller.sv
// fa_bist_controller: exhaustive BIST sequencer for a single-bit full adder.
// Walks all eight {a,b,c_in} vectors. Each vector is driven, allowed to settle
// for SETTLE_CYCLES cycles, and then checked against sum = a^b^c_in and
// c_out = majority(a,b,c_in). Failing vectors are counted in err_count.
//
// Parameters:
//   SETTLE_CYCLES    cycles spent in WAIT before sampling the adder (1..15)
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            run request, honoured in IDLE and DONE only
//   a, b, c_in       registered stimulus, equal to vec_idx (a = MSB) during a run
//   sum, c_out       adder-under-test responses
//   busy             run in progress (DRIVE/WAIT/CHECK)
//   done, pass       run complete; pass = done with no failures
//   err_count        failing vectors in current/last run (0..8)
//   vec_idx          vector currently applied
// Optional build macro FA_BIST_ERRLOG_EN adds:
//   first_fail_vec   index of the first failing vector of the run
//   first_fail_valid first_fail_vec holds a captured value
module fa_bist_controller #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c_in,
  input  logic       sum,
  input  logic       c_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
`ifdef FA_BIST_ERRLOG_EN
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid,
`endif
  output logic [2:0] vec_idx
);

  localparam int unsigned VecW    = 3;
  localparam int unsigned ErrW    = 4;
  localparam int unsigned CntW    = 4;
  localparam int unsigned ErrMax  = 8;
  localparam int unsigned LastVec = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CntW-1:0]   r_settle_cnt;
  logic [CntW-1:0]   w_settle_cnt_nxt;
  logic [VecW-1:0]   r_vec_idx;
  logic [VecW-1:0]   w_vec_idx_nxt;
  logic [VecW-1:0]   r_abc;
  logic [VecW-1:0]   w_abc_nxt;
  logic [ErrW-1:0]   r_err_count;
  logic [ErrW-1:0]   w_err_count_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_pass;
  logic              w_pass_nxt;
  logic              w_settle_last;
  logic              w_vec_fail;
`ifdef FA_BIST_ERRLOG_EN
  logic [VecW-1:0]   r_ff_vec;
  logic [VecW-1:0]   w_ff_vec_nxt;
  logic              r_ff_valid;
  logic              w_ff_valid_nxt;
`endif

  assign w_settle_last = (r_settle_cnt == CntW'(SETTLE_CYCLES - 1));

  // Golden full-adder comparison on the currently driven vector
  assign w_vec_fail = (sum != (r_abc[2] ^ r_abc[1] ^ r_abc[0])) ||
                      (c_out != ((r_abc[2] & r_abc[1]) | (r_abc[2] & r_abc[0]) |
                                 (r_abc[1] & r_abc[0])));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_DRIVE;
      S_DRIVE:        w_state_nxt = S_WAIT;
      S_WAIT:         if (w_settle_last) w_state_nxt = S_CHECK;
      S_CHECK:        w_state_nxt = (r_vec_idx == VecW'(LastVec)) ? S_DONE : S_DRIVE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values; every output is registered from these
  always_comb begin
    w_vec_idx_nxt    = r_vec_idx;
    w_abc_nxt        = r_abc;
    w_err_count_nxt  = r_err_count;
    w_settle_cnt_nxt = r_settle_cnt;
`ifdef FA_BIST_ERRLOG_EN
    w_ff_vec_nxt     = r_ff_vec;
    w_ff_valid_nxt   = r_ff_valid;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_vec_idx_nxt    = '0;
          w_abc_nxt        = '0;
          w_err_count_nxt  = '0;
          w_settle_cnt_nxt = '0;
`ifdef FA_BIST_ERRLOG_EN
          w_ff_vec_nxt     = '0;
          w_ff_valid_nxt   = 1'b0;
`endif
        end
      end
      S_DRIVE: w_settle_cnt_nxt = '0;
      S_WAIT:  if (!w_settle_last) w_settle_cnt_nxt = r_settle_cnt + CntW'(1);
      S_CHECK: begin
        // Saturating count; a vector contributes at most one error
        if (w_vec_fail && (r_err_count < ErrW'(ErrMax)))
          w_err_count_nxt = r_err_count + ErrW'(1);
`ifdef FA_BIST_ERRLOG_EN
        if (w_vec_fail && !r_ff_valid) begin
          w_ff_vec_nxt   = r_vec_idx;
          w_ff_valid_nxt = 1'b1;
        end
`endif
        if (r_vec_idx != VecW'(LastVec)) begin
          w_vec_idx_nxt = r_vec_idx + VecW'(1);
          w_abc_nxt     = r_vec_idx + VecW'(1);
        end
      end
      default: ;
    endcase
    w_busy_nxt = (w_state_nxt == S_DRIVE) || (w_state_nxt == S_WAIT) ||
                 (w_state_nxt == S_CHECK);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_pass_nxt = w_done_nxt && (w_err_count_nxt == '0);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec_idx    <= '0;
      r_abc        <= '0;
      r_err_count  <= '0;
      r_settle_cnt <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
`ifdef FA_BIST_ERRLOG_EN
      r_ff_vec     <= '0;
      r_ff_valid   <= 1'b0;
`endif
    end else begin
      r_vec_idx    <= w_vec_idx_nxt;
      r_abc        <= w_abc_nxt;
      r_err_count  <= w_err_count_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
`ifdef FA_BIST_ERRLOG_EN
      r_ff_vec     <= w_ff_vec_nxt;
      r_ff_valid   <= w_ff_valid_nxt;
`endif
    end
  end

  assign a         = r_abc[2];
  assign b         = r_abc[1];
  assign c_in      = r_abc[0];
  assign vec_idx   = r_vec_idx;
  assign err_count = r_err_count;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
`ifdef FA_BIST_ERRLOG_EN
  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;
`endif

endmodule

// File: doc/fa_bist_controller.md
FA_BIST_CONTROLLER -- requirements
Module: fa_bist_controller

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, meaning the cycles the adder outputs settle before sampling; legal range 1..15.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset: synchronous and active-low.
REQ-004 start  input  1  run request, sampled in IDLE and DONE only.
REQ-005 a  output  1  stimulus operand A to the full adder under test.
REQ-006 b  output  1  stimulus operand B.
REQ-007 c_in  output  1  stimulus carry-in.
REQ-008 sum  input  1  sum response from the adder under test.
REQ-009 c_out  input  1  carry-out response from the adder under test.
REQ-010 busy  output  1  high while a run is in progress (DRIVE, WAIT or CHECK).
REQ-011 done  output  1  high in DONE; the run is complete.
REQ-012 pass  output  1  high when done=1 and err_count=0.
REQ-013 err_count  output  4  number of failing vectors in the current or last run, 0..8.
REQ-014 vec_idx  output  3  index of the vector currently applied.

Function
REQ-015 The FSM SHALL have the states IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-016 IDLE with start=1: next state DRIVE, vec_idx=0, err_count=0; start=0 stays IDLE.
REQ-017 {a,b,c_in} SHALL be registered and equal vec_idx[2:0] (a = MSB) from DRIVE entry through CHECK.
REQ-018 DRIVE SHALL last exactly 1 cycle, then WAIT; WAIT SHALL last exactly SETTLE_CYCLES cycles, then CHECK.
REQ-019 CHECK SHALL compare sum with a^b^c_in and c_out with the majority of (a,b,c_in); a mismatch on either increments err_count by 1 (at most once per vector).
REQ-020 CHECK with vec_idx<7 SHALL increment vec_idx and go to DRIVE; CHECK with vec_idx=7 SHALL go to DONE with vec_idx held at 7.
REQ-021 done SHALL rise 8*(SETTLE_CYCLES+2) rising edges after the edge that samples start=1 in IDLE.
REQ-022 DONE SHALL hold err_count, pass and {a,b,c_in}; start=1 in DONE behaves as in REQ-016 (new run, counters cleared).
REQ-023 start during busy SHALL be ignored and SHALL NOT restart or extend the run.
REQ-024 err_count SHALL NOT wrap; its maximum is 8.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, a=b=c_in=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, and clear the settle counter.
REQ-026 Reset asserted mid-run SHALL abort the run with no partial result retained; the state after reset equals power-up.

Configuration
REQ-027 With FA_BIST_ERRLOG_EN defined, the block SHALL add outputs first_fail_vec (3 bits) and first_fail_valid (1 bit); the first failing CHECK of a run latches vec_idx and sets first_fail_valid; both clear on reset and on run start.
REQ-028 Without FA_BIST_ERRLOG_EN, those ports and their registers SHALL be absent and all other behaviour identical.

Verification
REQ-029 Correct full adder attached, SETTLE_CYCLES=1, start pulsed -> done after 24 edges, err_count=0, pass=1, vec_idx=7.
REQ-030 sum stuck at 0 -> err_count=4 (vectors 1,2,4,7), pass=0; with FA_BIST_ERRLOG_EN, first_fail_vec=1 and first_fail_valid=1.
REQ-031 c_out inverted -> err_count=8, pass=0; SETTLE_CYCLES=3 -> done after 40 edges.
REQ-032 start re-pulsed while busy at vector 3 -> run completes at the original done time; the count is unchanged by the pulse.
REQ-033 rst_n=0 for one edge while vec_idx=5 -> next cycle IDLE, all outputs 0; a new start gives a full clean run.
REQ-034 start=1 in DONE after a failing run -> err_count=0 and vec_idx=0 on the next edge, and busy=1.
